// File: rtl/systolic_pkg.sv
// Shared types and constants for the 3x3 systolic array sequencer.
package systolic_pkg;

  localparam int unsigned ARR_DIM  = 3;
  localparam int unsigned FEED_LEN = 2 * ARR_DIM - 1;
  localparam int unsigned BUF_N    = ARR_DIM * ARR_DIM;
  localparam int unsigned ADDR_W   = 4;
  localparam int unsigned T_W      = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FEED,
    ST_DRAIN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/systolic_skew_buf.sv
// A/B operand buffers with write port and the diagonal skew mux feeding the array edges.
module systolic_skew_buf
  import systolic_pkg::*;
#(
  parameter int unsigned data_size = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 busy,
  input  logic                 ld_en,
  input  logic                 ld_sel,
  input  logic [ADDR_W-1:0]    ld_addr,
  input  logic [data_size-1:0] ld_data,
  input  logic                 feed_en,
  input  logic [T_W-1:0]       t,
  output logic [data_size-1:0] a1,
  output logic [data_size-1:0] a2,
  output logic [data_size-1:0] a3,
  output logic [data_size-1:0] b1,
  output logic [data_size-1:0] b2,
  output logic [data_size-1:0] b3
);

  logic [data_size-1:0] a_buf [BUF_N];
  logic [data_size-1:0] b_buf [BUF_N];
  logic [data_size-1:0] a_nxt [ARR_DIM];
  logic [data_size-1:0] b_nxt [ARR_DIM];
  logic [data_size-1:0] a_q   [ARR_DIM];
  logic [data_size-1:0] b_q   [ARR_DIM];
  logic                 wr_ok;

  assign wr_ok = ld_en && !busy && (ld_addr < ADDR_W'(BUF_N));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < int'(BUF_N); n++) begin
        a_buf[n] <= '0;
        b_buf[n] <= '0;
      end
    end else if (wr_ok) begin
      if (ld_sel) b_buf[ld_addr] <= ld_data;
      else        a_buf[ld_addr] <= ld_data;
    end
  end

  // Row i sees A[i][t-i], column j sees B[t-j][j]; out-of-window slots feed zero.
  always_comb begin
    for (int i = 0; i < int'(ARR_DIM); i++) begin
      a_nxt[i] = '0;
      b_nxt[i] = '0;
      for (int k = 0; k < int'(ARR_DIM); k++) begin
        if (int'(t) == i + k) begin
          a_nxt[i] = a_buf[int'(ARR_DIM) * i + k];
          b_nxt[i] = b_buf[int'(ARR_DIM) * k + i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(ARR_DIM); i++) begin
      if (rst || !feed_en) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
      end else begin
        a_q[i] <= a_nxt[i];
        b_q[i] <= b_nxt[i];
      end
    end
  end

  assign a1 = a_q[0];
  assign a2 = a_q[1];
  assign a3 = a_q[2];
  assign b1 = b_q[0];
  assign b2 = b_q[1];
  assign b3 = b_q[2];

endmodule

// File: rtl/systolic_ctrl.sv
// Sequencer for the 3x3 output-stationary MAC array: clear, skewed feed, drain, done.
module systolic_ctrl
  import systolic_pkg::*;
#(
  parameter int unsigned data_size = 32,
  parameter int unsigned DRAIN_CYC = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ld_en,
  input  logic                 ld_sel,
  input  logic [ADDR_W-1:0]    ld_addr,
  input  logic [data_size-1:0] ld_data,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 arr_rst,
  output logic [data_size-1:0] a1,
  output logic [data_size-1:0] a2,
  output logic [data_size-1:0] a3,
  output logic [data_size-1:0] b1,
  output logic [data_size-1:0] b2,
  output logic [data_size-1:0] b3
);

  localparam int unsigned DRAIN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  state_t             state_q, state_d;
  logic [T_W-1:0]     t_q, t_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic               busy_d, done_d, feed_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      t_q     <= '0;
      drain_q <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      drain_q <= drain_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    drain_d = drain_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_CLEAR;
      ST_CLEAR: begin
        state_d = ST_FEED;
        t_d     = '0;
      end
      ST_FEED: begin
        if (t_q == T_W'(FEED_LEN - 1)) begin
          state_d = ST_DRAIN;
          drain_d = '0;
        end else begin
          t_d = t_q + T_W'(1);
        end
      end
      ST_DRAIN: begin
        if (drain_q == DRAIN_W'(DRAIN_CYC - 1)) state_d = ST_DONE;
        else                                    drain_d = drain_q + DRAIN_W'(1);
      end
      ST_DONE:  state_d = start ? ST_CLEAR : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    // Registered flags track the state being entered so they line up with it.
    busy_d = (state_d == ST_CLEAR) || (state_d == ST_FEED) || (state_d == ST_DRAIN);
    done_d = (state_d == ST_DONE);
    feed_d = (state_d == ST_FEED);
  end

  assign arr_rst = rst || (state_q == ST_CLEAR);

  systolic_skew_buf #(
    .data_size (data_size)
  ) u_skew_buf (
    .clk     (clk),
    .rst     (rst),
    .busy    (busy),
    .ld_en   (ld_en),
    .ld_sel  (ld_sel),
    .ld_addr (ld_addr),
    .ld_data (ld_data),
    .feed_en (feed_d),
    .t       (t_d),
    .a1      (a1),
    .a2      (a2),
    .a3      (a3),
    .b1      (b1),
    .b2      (b2),
    .b3      (b3)
  );

endmodule

// File: tb/tb_systolic_ctrl.sv
// Directed bench for systolic_ctrl driving a behavioural 3x3 output-stationary MAC array.
module tb_systolic_ctrl;

  logic        clk = 1'b0;
  logic        rst, ld_en, ld_sel, start;
  logic [3:0]  ld_addr;
  logic [31:0] ld_data;
  logic        busy, done, arr_rst;
  logic [31:0] a1, a2, a3, b1, b2, b3;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] exp_a [5][3];
  logic [31:0] exp_b [5][3];

  systolic_ctrl #(.data_size(32), .DRAIN_CYC(4)) dut (
    .clk(clk), .rst(rst), .ld_en(ld_en), .ld_sel(ld_sel), .ld_addr(ld_addr),
    .ld_data(ld_data), .start(start), .busy(busy), .done(done), .arr_rst(arr_rst),
    .a1(a1), .a2(a2), .a3(a3), .b1(b1), .b2(b2), .b3(b3)
  );

  always #5 clk = ~clk;

  // Array model: a flows right, b flows down, one register per PE hop.
  logic [31:0] a_in [3];
  logic [31:0] b_in [3];
  logic [31:0] pa   [3][2];
  logic [31:0] pb   [2][3];
  logic [31:0] acc  [3][3];

  assign a_in[0] = a1;
  assign a_in[1] = a2;
  assign a_in[2] = a3;
  assign b_in[0] = b1;
  assign b_in[1] = b2;
  assign b_in[2] = b3;

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        logic [31:0] av, bv;
        av = (j == 0) ? a_in[i] : pa[i][j-1];
        bv = (i == 0) ? b_in[j] : pb[i-1][j];
        acc[i][j] <= arr_rst ? 32'd0 : acc[i][j] + av * bv;
      end
      pa[i][0] <= arr_rst ? 32'd0 : a_in[i];
      pa[i][1] <= arr_rst ? 32'd0 : pa[i][0];
      pb[0][i] <= arr_rst ? 32'd0 : b_in[i];
      pb[1][i] <= arr_rst ? 32'd0 : pb[0][i];
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic sel, input int addr, input logic [31:0] data);
    ld_en   = 1'b1;
    ld_sel  = sel;
    ld_addr = 4'(addr);
    ld_data = data;
    tick();
    ld_en   = 1'b0;
  endtask

  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Called in the CLEAR cycle; returns in the DONE cycle.
  // mode 0: no feed check, 1: table check, 2: all-zero feed.
  task automatic run_from_clear(input int mode, input bit inject, input logic [31:0] a0);
    logic [31:0] e0;
    check("clear_arr_rst", 128'(arr_rst), 128'(1));
    check("clear_busy", 128'(busy), 128'(1));
    for (int t = 0; t < 5; t++) begin
      if (inject && t == 2) begin
        start = 1'b1; ld_en = 1'b1; ld_sel = 1'b0; ld_addr = 4'd0; ld_data = 32'd99;
      end
      tick();
      start = 1'b0; ld_en = 1'b0;
      if (mode == 1) begin
        e0 = (t == 0) ? a0 : exp_a[t][0];
        check($sformatf("feed_a_t%0d", t), 128'({a1, a2, a3}), 128'({e0, exp_a[t][1], exp_a[t][2]}));
        check($sformatf("feed_b_t%0d", t), 128'({b1, b2, b3}), 128'({exp_b[t][0], exp_b[t][1], exp_b[t][2]}));
      end else if (mode == 2) begin
        check($sformatf("zero_feed_t%0d", t), 128'({a1, a2, a3, b1}), 128'(0));
      end
      check($sformatf("feed_busy_t%0d", t), 128'({busy, done}), 128'(2'b10));
    end
    for (int d = 0; d < 4; d++) begin
      tick();
      check($sformatf("drain_ab_%0d", d), 128'({a1, a2, a3, b1}) | 128'({b2, b3}), 128'(0));
      check($sformatf("drain_flags_%0d", d), 128'({busy, done}), 128'(2'b10));
    end
    tick();
    check("done_flags", 128'({busy, done, arr_rst}), 128'(3'b010));
  endtask

  initial begin
    exp_a[0] = '{32'd1, 32'd0, 32'd0};  exp_b[0] = '{32'd10, 32'd0,  32'd0};
    exp_a[1] = '{32'd2, 32'd4, 32'd0};  exp_b[1] = '{32'd13, 32'd11, 32'd0};
    exp_a[2] = '{32'd3, 32'd5, 32'd7};  exp_b[2] = '{32'd16, 32'd14, 32'd12};
    exp_a[3] = '{32'd0, 32'd6, 32'd8};  exp_b[3] = '{32'd0,  32'd17, 32'd15};
    exp_a[4] = '{32'd0, 32'd0, 32'd9};  exp_b[4] = '{32'd0,  32'd0,  32'd18};

    rst = 1'b1; ld_en = 1'b0; ld_sel = 1'b0; ld_addr = '0; ld_data = '0; start = 1'b0;
    repeat (3) tick();
    check("rst_ab", 128'({a1, a2, a3, b1}) | 128'({b2, b3}), 128'(0));
    check("rst_flags", 128'({busy, done, arr_rst}), 128'(3'b001));
    rst = 1'b0;
    tick();
    check("idle_flags", 128'({busy, done, arr_rst}), 128'(3'b000));

    // Feed order with A=1..9, B=10..18
    for (int k = 0; k < 9; k++) load(1'b0, k, 32'(k + 1));
    for (int k = 0; k < 9; k++) load(1'b1, k, 32'(k + 10));
    start_run();
    run_from_clear(1, 1'b0, 32'd1);
    tick();
    check("post_done_idle", 128'({busy, done, arr_rst}), 128'(3'b000));

    // Out-of-range address, start and write while busy are all ignored
    load(1'b0, 12, 32'd77);
    load(1'b1, 12, 32'd77);
    start_run();
    run_from_clear(1, 1'b1, 32'd1);
    tick();
    check("no_restart_idle", 128'({busy, done}), 128'(2'b00));

    // Back-to-back: start and an A[0] rewrite in the DONE cycle
    start_run();
    run_from_clear(1, 1'b0, 32'd1);
    start = 1'b1; ld_en = 1'b1; ld_sel = 1'b0; ld_addr = 4'd0; ld_data = 32'd50;
    tick();
    start = 1'b0; ld_en = 1'b0;
    run_from_clear(1, 1'b0, 32'd50);
    tick();

    // Integration: A=1..9, B=identity
    for (int k = 0; k < 9; k++) load(1'b0, k, 32'(k + 1));
    for (int k = 0; k < 9; k++) load(1'b1, k, (k % 4 == 0) ? 32'd1 : 32'd0);
    start_run();
    run_from_clear(0, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        check($sformatf("ident_c%0d", 3*i + j + 1), 128'(acc[i][j]), 128'(3*i + j + 1));
    tick();

    // Integration: all-2 times all-3
    for (int k = 0; k < 9; k++) load(1'b0, k, 32'd2);
    for (int k = 0; k < 9; k++) load(1'b1, k, 32'd3);
    start_run();
    run_from_clear(0, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        check($sformatf("const_c%0d", 3*i + j + 1), 128'(acc[i][j]), 128'(18));
    tick();

    // Reset in the middle of FEED at t=2
    start_run();
    tick(); tick(); tick();
    check("pre_rst_t2_a", 128'({a1, a2, a3}), 128'({32'd2, 32'd2, 32'd2}));
    rst = 1'b1;
    tick();
    check("midrst_ab", 128'({a1, a2, a3, b1}) | 128'({b2, b3}), 128'(0));
    check("midrst_flags", 128'({busy, done, arr_rst}), 128'(3'b001));
    rst = 1'b0;
    begin
      logic saw_done;
      saw_done = 1'b0;
      for (int c = 0; c < 12; c++) begin
        tick();
        saw_done = saw_done | done | busy;
      end
      check("midrst_no_done", 128'(saw_done), 128'(0));
    end
    start_run();
    run_from_clear(2, 1'b0, 32'd0);
    check("midrst_c9_zero", 128'(acc[2][2]), 128'(0));
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/systolic_ctrl.md
Name: systolic_ctrl

Overview:
- Sequencer for the 3x3 output-stationary MAC systolic array.
- Holds one 3x3 A matrix and one 3x3 B matrix in local register buffers, loaded through a simple write port.
- On start, it clears the array accumulators, then drives the row inputs a1..a3 and column inputs b1..b3 with diagonally skewed operands.
- It waits a fixed drain interval, then pulses done; at that point the array outputs c1..c9 hold A×B.

Parameters:
- data_size, 32, operand and bus width; matches the array.
- DRAIN_CYC, 4, cycles of zero feed after the last operand, before done; covers propagation to the far MAC plus accumulator latency.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ld_en  in  1  buffer write strobe
- ld_sel  in  1  0 = write A buffer, 1 = write B buffer
- ld_addr  in  4  element index, row-major: addr = 3*row + col, valid range 0..8
- ld_data  in  data_size  element value
- start  in  1  begin a multiply
- busy  out  1  high from the cycle after start is accepted until the cycle before done
- done  out  1  one-cycle pulse; array results are valid in this cycle
- arr_rst  out  1  reset to all array MACs
- a1, a2, a3  out  data_size each  array row inputs
- b1, b2, b3  out  data_size each  array column inputs

Behaviour:
- Reset values:
  - Next edge with rst=1: state IDLE; both buffers cleared to 0.
  - a*, b* = 0; busy = 0; done = 0.
  - arr_rst = 1 while rst is high.
- States and transitions:
  - IDLE: start=1 -> CLEAR.
  - CLEAR: lasts exactly 1 cycle; arr_rst=1, a*/b* = 0. Next state FEED with t=0.
  - FEED: lasts 5 cycles, t = 0..4 (3-bit counter). Next state DRAIN.
  - DRAIN: lasts DRAIN_CYC cycles; a*/b* = 0. Next state DONE.
  - DONE: lasts 1 cycle; done=1, busy=0. Next state IDLE, or CLEAR if start=1 in this cycle (back-to-back).
- arr_rst = rst OR (state == CLEAR). It is the only combinational output.
- a*, b* are registered: the value for feed step t appears on the clock edge that enters step t.
- Skew rule in FEED:
  - a_i (i = 0..2 for a1..a3) = A[i][t-i] if 0 <= t-i <= 2, else 0.
  - b_j (j = 0..2 for b1..b3) = B[t-j][j] if 0 <= t-j <= 2, else 0.
- Buffer writes:
  - Accepted only when busy=0, including the DONE cycle; ld_en while busy is ignored.
  - ld_addr 9..15 is ignored; no buffer change.
  - Data written in the DONE cycle is used by a back-to-back run.
- start is ignored in CLEAR, FEED and DRAIN.
- Reset mid-operation (any state): the next edge forces IDLE, buffers cleared, outputs zero. There is no partial done pulse.
- Latency: start accepted at edge 0; done high in cycle 1 + 1 + 5 + DRAIN_CYC = 11 at the default.
- Arithmetic: none in this block; operand widths pass through unchanged. Overflow behaviour is that of the array.

Decomposition:
- Shared package holds:
  - State encoding: IDLE, CLEAR, FEED, DRAIN, DONE.
  - Constants ARR_DIM = 3 and FEED_LEN = 2*ARR_DIM - 1.
  - Index width for ld_addr.
- One sub-module is natural: systolic_skew_buf.
  - Contents: the 9-entry A and B register buffers, the write port, and the skew mux producing a*/b* from t.
  - The FSM and counters stay in systolic_ctrl.

Test Plan:
- Reset: hold rst 3 cycles -> a*/b*=0, busy=0, done=0, arr_rst=1. After release: arr_rst=0, state IDLE.
- Feed order:
  - Stimulus: load A=1..9 row-major, B=10..18; pulse start.
  - CLEAR cycle: arr_rst=1.
  - t=0: a=(1,0,0), b=(10,0,0).
  - t=1: a=(2,4,0), b=(13,11,0).
  - t=2: a=(3,5,7), b=(16,14,12).
  - t=3: a=(0,6,8), b=(0,17,15).
  - t=4: a=(0,0,9), b=(0,0,18).
  - Then zeros for 4 cycles; done in cycle 11.
- Integration with the array:
  - A=1..9, B=identity -> at done, c1..c9 = 1..9.
  - A=all 2, B=all 3 -> every c = 18.
- Protocol:
  - start during FEED is ignored: no restart, done still at cycle 11.
  - ld_en during busy writing A[0]=99 has no effect; the next run still feeds 1.
  - ld_addr=12 write is ignored.
- Reset mid-FEED at t=2 -> next cycle IDLE, outputs 0, busy=0, no done. Reading after a fresh start shows the buffers zero.
- Back-to-back:
  - Stimulus: start held high through DONE.
  - Required: CLEAR follows immediately, second done at 11 cycles after the first.
  - A buffer rewritten in the DONE cycle is reflected in the second feed.
